cmd_stim_seq: RTL and testbench
===============================

Name: cmd_stim_seq

Overview:
- Programmable, parametrised command stimulus sequencer for the arithmetic command datapath.
- Replaces fixed per-cycle stimulus tables with a loadable command table, a valid/ready issue handshake with backpressure, and one-shot or loop modes.
- Tracks in-order completions (done_i/done_cmd_i) against the issued command stream and flags mismatches.
- Sits between the bench/config host and the DUT command interface.

Parameters:
- DEPTH, 16, command table entries (power of 2).
- IDX_W, 4, log2(DEPTH).
- DATA_W, 64, operand width.
- MAX_OUT, 4, maximum outstanding (issued, not yet done) commands; depth of the expect FIFO.
- CNT_W, 16, width of the issue/done counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  table write strobe; ignored while busy=1
- cfg_addr  in  IDX_W  table write address
- cfg_cmd  in  3  command code: RST=0, INIT=1, ADD=2, SUB=3, MULT=4, DIV=5, REM=6, HLT=7
- cfg_opd1  in  DATA_W  operand 1 for table entry
- cfg_opd2  in  DATA_W  operand 2 for table entry
- cfg_len  in  IDX_W+1  number of valid entries, 1..DEPTH; sampled on start
- loop_en  in  1  1 = wrap to entry 0 after the last entry; sampled on start
- start  in  1  begin a sequence; ignored while busy=1
- stop  in  1  request early end of the sequence
- cmd_vld  out  1  command valid
- cmd_rdy  in  1  DUT accepts command
- cmd_o  out  3  command code
- opd1_o  out  DATA_W  operand 1
- opd2_o  out  DATA_W  operand 2
- done_i  in  1  DUT completion strobe, one per command, in issue order
- done_cmd_i  in  3  command code of the completing command
- busy  out  1  sequencer not IDLE
- idx_o  out  IDX_W  table index of the currently presented entry
- outstanding  out  $clog2(MAX_OUT)+1  issued but not yet completed
- issue_cnt  out  CNT_W  transfers since start; wraps
- done_cnt  out  CNT_W  completions since start; wraps
- mismatch  out  1  sticky: done_cmd_i differed from the expected code, or done_i arrived with nothing outstanding
- seq_done  out  1  one-cycle pulse on DRAIN->IDLE

Behaviour:
- Reset: every output is 0. State goes to IDLE and the expect FIFO is emptied. Table contents are not reset. Reset mid-sequence abandons all outstanding commands, with no seq_done pulse.
- Table: written synchronously on cfg_we when busy=0.
- IDLE:
  - start with cfg_len!=0 -> RUN. Clear the counters and mismatch. Load entry 0 into cmd_o/opd1_o/opd2_o and set idx_o=0. cmd_vld rises the cycle after start is sampled.
  - start with cfg_len=0 -> no state change; seq_done pulses the next cycle.
- RUN:
  - cmd_vld may rise only when outstanding<MAX_OUT.
  - Once high, cmd_vld and the payload stay stable until the transfer (cmd_vld&&cmd_rdy).
  - On a transfer:
    - Push cmd_o into the expect FIFO and increment issue_cnt.
    - If cmd_o==HLT, or stop was seen, or (idx_o==cfg_len-1 and loop_en=0): cmd_vld drops the next cycle and the state goes to DRAIN.
    - Otherwise load the next entry the next cycle (idx_o+1, or 0 on wrap when loop_en=1). cmd_vld stays high if outstanding after the push is <MAX_OUT; back-to-back issue is 1 per cycle.
  - stop: registered as a pending stop.
    - If cmd_vld=0 at that point -> DRAIN immediately.
    - If cmd_vld=1 -> the current command completes its handshake first; a valid is never withdrawn.
- DRAIN: no new issue. When outstanding==0 -> IDLE, pulse seq_done, busy=0.
- Completion (any state):
  - done_i pops the FIFO head and increments done_cnt.
  - If head!=done_cmd_i, set mismatch.
  - done_i with an empty FIFO sets mismatch; there is no pop and done_cnt still increments.
  - Push and pop in the same cycle leave outstanding unchanged.
- Counters wrap modulo 2^CNT_W. mismatch clears only on start or reset.

Test Plan:
- Load 4 entries {INIT 1,1; ADD 5,3; SUB 9,2; MULT 3,4}, cfg_len=4, loop_en=0, cmd_rdy=1, DUT returns each done 2 cycles after issue -> cmd_vld high 4 consecutive cycles in that order; issue_cnt=4, done_cnt=4, mismatch=0; one seq_done pulse.
- Same load with cmd_rdy held low 3 cycles on the ADD -> cmd_o=ADD, opd1_o=5, opd2_o=3 held stable for those 3 cycles; no skip or duplicate.
- MAX_OUT=4, 8 ADD entries, no done_i -> exactly 4 transfers, then cmd_vld=0 and outstanding=4. One done_i -> exactly one further issue.
- Entries {ADD, HLT, SUB}, cfg_len=3, loop_en=1 -> ADD and HLT issued, SUB never issued; DRAIN, then seq_done.
- Entries {ADD, DIV}, loop_en=1, assert stop after issue_cnt=5 -> issue_cnt ends at 5 or 6 (never a dropped valid); idx_o wraps 1->0; done_cnt equals issue_cnt before seq_done.
- done_cmd_i=SUB returned for an issued ADD -> mismatch=1 and stays 1 until the next start. rst asserted mid-RUN -> all outputs 0 next cycle; outstanding=0.

Source files
------------

// File: rtl/cmd_stim_seq.sv
// Loadable command-table stimulus sequencer: issues entries over a valid/ready
// handshake and checks in-order completions against an expect FIFO.
module cmd_stim_seq #(
  parameter int DEPTH   = 16,
  parameter int IDX_W   = 4,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [IDX_W-1:0]            cfg_addr,
  input  logic [2:0]                  cfg_cmd,
  input  logic [DATA_W-1:0]           cfg_opd1,
  input  logic [DATA_W-1:0]           cfg_opd2,
  input  logic [IDX_W:0]              cfg_len,
  input  logic                        loop_en,
  input  logic                        start,
  input  logic                        stop,
  output logic                        cmd_vld,
  input  logic                        cmd_rdy,
  output logic [2:0]                  cmd_o,
  output logic [DATA_W-1:0]           opd1_o,
  output logic [DATA_W-1:0]           opd2_o,
  input  logic                        done_i,
  input  logic [2:0]                  done_cmd_i,
  output logic                        busy,
  output logic [IDX_W-1:0]            idx_o,
  output logic [$clog2(MAX_OUT):0]    outstanding,
  output logic [CNT_W-1:0]            issue_cnt,
  output logic [CNT_W-1:0]            done_cnt,
  output logic                        mismatch,
  output logic                        seq_done
);
  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [OUT_W-1:0] MAX_OUT_L = OUT_W'(MAX_OUT);
  localparam logic [2:0] CMD_HLT = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  logic [2:0]        tbl_cmd  [DEPTH];
  logic [DATA_W-1:0] tbl_opd1 [DEPTH];
  logic [DATA_W-1:0] tbl_opd2 [DEPTH];
  logic [2:0]        exp_fifo [MAX_OUT];

  state_t            state_q;
  logic [IDX_W:0]    len_q;
  logic              loop_q, stop_q, cmd_vld_q, mismatch_q, seq_done_q;
  logic [2:0]        cmd_q;
  logic [DATA_W-1:0] opd1_q, opd2_q;
  logic [IDX_W-1:0]  idx_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  issue_cnt_q, done_cnt_q;

  logic             xfer, pop, at_last, end_seq, room;
  logic [IDX_W-1:0] idx_nxt;

  always_comb begin
    xfer    = cmd_vld_q && cmd_rdy;
    pop     = done_i && (out_q != '0);
    at_last = ({1'b0, idx_q} == (len_q - 1'b1));
    end_seq = (cmd_q == CMD_HLT) || stop_q || stop || (at_last && !loop_q);
    idx_nxt = at_last ? '0 : idx_q + 1'b1;
    out_d   = out_q;
    if (xfer && !pop)
      out_d = out_q + 1'b1;
    else if (!xfer && pop)
      out_d = out_q - 1'b1;
    // Room is judged on next cycle's count so a same-cycle completion frees a slot.
    room = (out_d < MAX_OUT_L);
  end

  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE) begin
      tbl_cmd[cfg_addr]  <= cfg_cmd;
      tbl_opd1[cfg_addr] <= cfg_opd1;
      tbl_opd2[cfg_addr] <= cfg_opd2;
    end
    if (xfer)
      exp_fifo[wr_ptr_q] <= cmd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      loop_q      <= 1'b0;
      stop_q      <= 1'b0;
      cmd_vld_q   <= 1'b0;
      cmd_q       <= '0;
      opd1_q      <= '0;
      opd2_q      <= '0;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_q       <= '0;
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
      mismatch_q  <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      seq_done_q <= 1'b0;
      out_q      <= out_d;
      if (xfer) begin
        wr_ptr_q    <= wr_ptr_q + 1'b1;
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
      if (done_i) begin
        done_cnt_q <= done_cnt_q + 1'b1;
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          if (exp_fifo[rd_ptr_q] != done_cmd_i)
            mismatch_q <= 1'b1;
        end else begin
          mismatch_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start && cfg_len != '0) begin
            state_q     <= S_RUN;
            len_q       <= cfg_len;
            loop_q      <= loop_en;
            stop_q      <= 1'b0;
            idx_q       <= '0;
            cmd_q       <= tbl_cmd[0];
            opd1_q      <= tbl_opd1[0];
            opd2_q      <= tbl_opd2[0];
            cmd_vld_q   <= (out_q < MAX_OUT_L);
            issue_cnt_q <= '0;
            done_cnt_q  <= '0;
            mismatch_q  <= 1'b0;
          end else if (start) begin
            seq_done_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (end_seq) begin
              cmd_vld_q <= 1'b0;
              state_q   <= S_DRAIN;
            end else begin
              idx_q     <= idx_nxt;
              cmd_q     <= tbl_cmd[idx_nxt];
              opd1_q    <= tbl_opd1[idx_nxt];
              opd2_q    <= tbl_opd2[idx_nxt];
              cmd_vld_q <= room;
            end
          end else if (!cmd_vld_q) begin
            if (stop || stop_q)
              state_q <= S_DRAIN;
            else if (room)
              cmd_vld_q <= 1'b1;
          end else if (stop) begin
            // A presented valid is never withdrawn; finish its handshake first.
            stop_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_q == '0) begin
            state_q    <= S_IDLE;
            seq_done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_vld     = cmd_vld_q;
  assign cmd_o       = cmd_q;
  assign opd1_o      = opd1_q;
  assign opd2_o      = opd2_q;
  assign busy        = (state_q != S_IDLE);
  assign idx_o       = idx_q;
  assign outstanding = out_q;
  assign issue_cnt   = issue_cnt_q;
  assign done_cnt    = done_cnt_q;
  assign mismatch    = mismatch_q;
  assign seq_done    = seq_done_q;
endmodule

// File: tb/tb_cmd_stim_seq.sv
// Directed bench for cmd_stim_seq: table-driven basic run plus hand-written
// backpressure, outstanding-limit, HLT, stop, mismatch and reset sequences.
module tb_cmd_stim_seq;
  localparam int DEPTH = 16, IDX_W = 4, DATA_W = 64, MAX_OUT = 4, CNT_W = 16;
  localparam logic [2:0] C_INIT = 3'd1, C_ADD = 3'd2, C_SUB = 3'd3, C_MULT = 3'd4,
                         C_DIV = 3'd5, C_HLT = 3'd7;

  logic clk = 1'b0;
  logic rst, cfg_we, loop_en, start, stop, cmd_rdy, done_i;
  logic [IDX_W-1:0] cfg_addr;
  logic [2:0] cfg_cmd, done_cmd_i;
  logic [DATA_W-1:0] cfg_opd1, cfg_opd2;
  logic [IDX_W:0] cfg_len;
  logic cmd_vld, busy, mismatch, seq_done;
  logic [2:0] cmd_o;
  logic [DATA_W-1:0] opd1_o, opd2_o;
  logic [IDX_W-1:0] idx_o;
  logic [$clog2(MAX_OUT):0] outstanding;
  logic [CNT_W-1:0] issue_cnt, done_cnt;

  always #5 clk = ~clk;

  cmd_stim_seq #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_cmd(cfg_cmd),
    .cfg_opd1(cfg_opd1), .cfg_opd2(cfg_opd2), .cfg_len(cfg_len), .loop_en(loop_en),
    .start(start), .stop(stop), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_o(cmd_o),
    .opd1_o(opd1_o), .opd2_o(opd2_o), .done_i(done_i), .done_cmd_i(done_cmd_i),
    .busy(busy), .idx_o(idx_o), .outstanding(outstanding), .issue_cnt(issue_cnt),
    .done_cnt(done_cnt), .mismatch(mismatch), .seq_done(seq_done));

  // Auto-responder returns each transferred command two cycles later.
  logic resp_en, man_done;
  logic [2:0] man_code, resp_xor;
  logic d1_v, d2_v, resp_done;
  logic [2:0] d1_c, d2_c, resp_code;
  assign done_i     = resp_en ? resp_done : man_done;
  assign done_cmd_i = resp_en ? resp_code : man_code;

  always @(posedge clk) begin
    logic x;
    logic [2:0] c;
    x = cmd_vld && cmd_rdy;
    c = cmd_o;
    #1;
    resp_done = d2_v;
    resp_code = d2_c ^ resp_xor;
    d2_v = d1_v;
    d2_c = d1_c;
    d1_v = x && !rst;
    d1_c = c;
  end

  typedef struct {
    logic [2:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [IDX_W-1:0]  idx;
    int                cyc;
  } xfer_t;
  xfer_t xq[$];
  int cyc = 0;
  int sd_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (seq_done) sd_cnt++;
    if (!rst && cmd_vld && cmd_rdy)
      xq.push_back('{cmd: cmd_o, op1: opd1_o, op2: opd2_o, idx: idx_o, cyc: cyc});
  end

  typedef struct {
    logic [2:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [2:0]        exp_cmd;
    logic [DATA_W-1:0] exp_op1;
    logic [DATA_W-1:0] exp_op2;
  } vec_t;
  vec_t vecs[4];

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IDX_W-1:0] a, input logic [2:0] c,
                      input logic [DATA_W-1:0] o1, input logic [DATA_W-1:0] o2);
    cfg_we = 1'b1; cfg_addr = a; cfg_cmd = c; cfg_opd1 = o1; cfg_opd2 = o2;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_seq(input logic [IDX_W:0] len, input logic lp);
    cfg_len = len; loop_en = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string nm);
    int k;
    k = 0;
    while (sd_cnt == base && k < 300) begin
      tick();
      k++;
    end
    check(nm, 64'(sd_cnt != base), 64'd1);
  endtask

  initial begin
    int base;
    int k;
    rst = 1'b1; cfg_we = 0; cfg_addr = '0; cfg_cmd = '0; cfg_opd1 = '0; cfg_opd2 = '0;
    cfg_len = '0; loop_en = 0; start = 0; stop = 0; cmd_rdy = 0;
    resp_en = 0; man_done = 0; man_code = '0; resp_xor = '0;
    d1_v = 0; d2_v = 0; d1_c = '0; d2_c = '0; resp_done = 0; resp_code = '0;
    vecs[0] = '{C_INIT, 64'd1, 64'd1, C_INIT, 64'd1, 64'd1};
    vecs[1] = '{C_ADD,  64'd5, 64'd3, C_ADD,  64'd5, 64'd3};
    vecs[2] = '{C_SUB,  64'd9, 64'd2, C_SUB,  64'd9, 64'd2};
    vecs[3] = '{C_MULT, 64'd3, 64'd4, C_MULT, 64'd3, 64'd4};
    tick(); tick();
    rst = 1'b0;
    check("rst_vld", 64'(cmd_vld), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_out", 64'(outstanding), 0);
    check("rst_issue", 64'(issue_cnt), 0);
    check("rst_mism", 64'(mismatch), 0);
    check("rst_cmd", 64'(cmd_o), 0);

    // Basic 4-entry run, table-driven.
    for (int i = 0; i < 4; i++) load(IDX_W'(i), vecs[i].cmd, vecs[i].op1, vecs[i].op2);
    xq.delete(); cmd_rdy = 1; resp_en = 1; base = sd_cnt;
    start_seq(5'd4, 1'b0);
    check("t1_vld_after_start", 64'(cmd_vld), 1);
    wait_done(base, "t1_seq_done_timeout");
    check("t1_nxfer", 64'(xq.size()), 4);
    for (int i = 0; i < 4 && i < xq.size(); i++) begin
      check($sformatf("t1_cmd%0d", i), 64'(xq[i].cmd), 64'(vecs[i].exp_cmd));
      check($sformatf("t1_op1_%0d", i), xq[i].op1, vecs[i].exp_op1);
      check($sformatf("t1_op2_%0d", i), xq[i].op2, vecs[i].exp_op2);
    end
    if (xq.size() == 4) check("t1_back2back", 64'(xq[3].cyc - xq[0].cyc), 3);
    check("t1_issue", 64'(issue_cnt), 4);
    check("t1_done", 64'(done_cnt), 4);
    check("t1_mism", 64'(mismatch), 0);
    check("t1_busy", 64'(busy), 0);
    tick(); tick();
    check("t1_one_pulse", 64'(sd_cnt - base), 1);

    // Backpressure on ADD for 3 cycles.
    xq.delete(); base = sd_cnt;
    start_seq(5'd4, 1'b0);
    tick();
    check("t2_add_shown", 64'(cmd_o), 64'(C_ADD));
    cmd_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t2_hold_vld%0d", i), 64'(cmd_vld), 1);
      check($sformatf("t2_hold_cmd%0d", i), 64'(cmd_o), 64'(C_ADD));
      check($sformatf("t2_hold_op%0d", i), {opd1_o[31:0], opd2_o[31:0]}, {32'd5, 32'd3});
    end
    cmd_rdy = 1;
    wait_done(base, "t2_seq_done_timeout");
    check("t2_nxfer", 64'(xq.size()), 4);
    for (int i = 0; i < 4 && i < xq.size(); i++)
      check($sformatf("t2_cmd%0d", i), 64'(xq[i].cmd), 64'(vecs[i].exp_cmd));

    // Outstanding limit: 8 ADDs, completions held back.
    for (int i = 0; i < 8; i++) load(IDX_W'(i), C_ADD, 64'(i), 64'd1);
    xq.delete(); resp_en = 0; base = sd_cnt;
    start_seq(5'd8, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check("t3_nxfer4", 64'(xq.size()), 4);
    check("t3_vld_low", 64'(cmd_vld), 0);
    check("t3_out4", 64'(outstanding), 4);
    man_done = 1; man_code = C_ADD;
    tick();
    man_done = 0;
    for (int i = 0; i < 5; i++) tick();
    check("t3_nxfer5", 64'(xq.size()), 5);
    check("t3_out4b", 64'(outstanding), 4);
    stop = 1;
    tick();
    stop = 0;
    man_done = 1;
    for (int i = 0; i < 4; i++) tick();
    man_done = 0;
    wait_done(base, "t3_seq_done_timeout");
    check("t3_issue", 64'(issue_cnt), 5);
    check("t3_done", 64'(done_cnt), 5);
    check("t3_mism", 64'(mismatch), 0);

    // HLT ends a looping sequence.
    load(0, C_ADD, 64'd1, 64'd2); load(1, C_HLT, 64'd0, 64'd0); load(2, C_SUB, 64'd7, 64'd7);
    xq.delete(); resp_en = 1; base = sd_cnt;
    start_seq(5'd3, 1'b1);
    wait_done(base, "t4_seq_done_timeout");
    check("t4_nxfer", 64'(xq.size()), 2);
    if (xq.size() >= 2) begin
      check("t4_cmd0", 64'(xq[0].cmd), 64'(C_ADD));
      check("t4_cmd1", 64'(xq[1].cmd), 64'(C_HLT));
    end
    check("t4_done", 64'(done_cnt), 2);

    // Looping {ADD, DIV} stopped after 5 issues.
    load(0, C_ADD, 64'd4, 64'd4); load(1, C_DIV, 64'd8, 64'd2);
    xq.delete(); base = sd_cnt;
    start_seq(5'd2, 1'b1);
    k = 0;
    while (issue_cnt < 5 && k < 50) begin tick(); k++; end
    check("t5_reach5_timeout", 64'(k < 50), 1);
    stop = 1;
    tick();
    stop = 0;
    wait_done(base, "t5_seq_done_timeout");
    check("t5_issue_5or6", 64'(issue_cnt == 5 || issue_cnt == 6), 1);
    check("t5_done_eq", 64'(done_cnt), 64'(issue_cnt));
    if (xq.size() >= 3) begin
      check("t5_idx1", 64'(xq[1].idx), 1);
      check("t5_wrap_idx", 64'(xq[2].idx), 0);
      check("t5_wrap_cmd", 64'(xq[2].cmd), 64'(C_ADD));
    end

    // Wrong completion code sets sticky mismatch.
    load(0, C_ADD, 64'd1, 64'd1);
    resp_xor = 3'd1; base = sd_cnt;
    start_seq(5'd1, 1'b0);
    wait_done(base, "t6_seq_done_timeout");
    resp_xor = 3'd0;
    check("t6_mism", 64'(mismatch), 1);
    tick(); tick();
    check("t6_mism_sticky", 64'(mismatch), 1);

    // Next start clears mismatch; reset mid-run clears everything.
    for (int i = 0; i < 4; i++) load(IDX_W'(i), vecs[i].cmd, vecs[i].op1, vecs[i].op2);
    resp_en = 0;
    start_seq(5'd4, 1'b0);
    check("t7_mism_cleared", 64'(mismatch), 0);
    tick(); tick();
    check("t7_out_pre", 64'(outstanding), 2);
    rst = 1;
    tick();
    rst = 0;
    check("t7_rst_vld", 64'(cmd_vld), 0);
    check("t7_rst_busy", 64'(busy), 0);
    check("t7_rst_out", 64'(outstanding), 0);
    check("t7_rst_issue", 64'(issue_cnt), 0);
    check("t7_rst_cmd_op", {61'd0, cmd_o} | opd1_o | opd2_o | 64'(idx_o), 0);

    // Completion with nothing outstanding, then zero-length start.
    man_done = 1; man_code = C_ADD;
    tick();
    man_done = 0;
    check("t8_empty_mism", 64'(mismatch), 1);
    check("t8_empty_donecnt", 64'(done_cnt), 1);
    check("t8_empty_out", 64'(outstanding), 0);
    start_seq(5'd0, 1'b0);
    check("t8_len0_pulse", 64'(seq_done), 1);
    check("t8_len0_busy", 64'(busy), 0);
    tick();
    check("t8_len0_pulse_end", 64'(seq_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
